// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Shares one external combinational adder (y = a + b + cin, no carry-out)
//   between two requesters. Operand requests arrive on valid/ready. One winner
//   is chosen round-robin. Its operands are registered onto the adder inputs,
//   the adder result is captured one cycle later, and that result is returned
//   on a response handshake that is held until the winner accepts it.
//
//   Ports
//     clk, rst                 clock (rising edge), synchronous active-high reset
//     rN_valid / rN_ready      requester N operand handshake (N = 0, 1)
//     rN_a, rN_b, rN_cin       requester N operands
//     rN_rsp_valid / _ready    requester N result handshake
//     rN_y                     requester N result (holds last returned value)
//     add_a, add_b, add_cin    registered operands to the shared adder
//     add_y                    result from the shared adder
//     busy                     high whenever an operation is in flight
module adder_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r0_cin,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [WIDTH-1:0] r0_y,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic             r1_cin,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] r1_y,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_y,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic             r_grant;       // requester owning the in-flight op
  logic             r_last_grant;  // requester served most recently

  logic             w_req_any;
  logic             w_grant;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_sel_cin;
  logic             w_rsp_ready;

  // Under contention the requester that was not served last wins; with a
  // single request that requester wins regardless of history.
  always_comb begin
    w_req_any = r0_valid | r1_valid;
    if (r0_valid && r1_valid) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = r1_valid;
    end
    w_accept    = (r_state == S_IDLE) && w_req_any;
    w_sel_a     = w_grant ? r1_a   : r0_a;
    w_sel_b     = w_grant ? r1_b   : r0_b;
    w_sel_cin   = w_grant ? r1_cin : r0_cin;
    w_rsp_ready = r_grant ? r1_rsp_ready : r0_rsp_ready;
  end

  assign r0_ready     = w_accept && !w_grant;
  assign r1_ready     = w_accept &&  w_grant;
  assign r0_rsp_valid = (r_state == S_RESP) && !r_grant;
  assign r1_rsp_valid = (r_state == S_RESP) &&  r_grant;
  assign busy         = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;   // makes requester 0 win the first contention
      add_a        <= '0;
      add_b        <= '0;
      add_cin      <= 1'b0;
      r0_y         <= '0;
      r1_y         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            add_a   <= w_sel_a;
            add_b   <= w_sel_b;
            add_cin <= w_sel_cin;
            r_grant <= w_grant;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          // Adder has had a full cycle to settle on the registered operands.
          // The result goes straight into the winner's result register, so
          // the other requester's y keeps its last returned value.
          if (r_grant) begin
            r1_y <= add_y;
          end else begin
            r0_y <= add_y;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_ready) begin
            r_last_grant <= r_grant;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter: models the shared adder, keeps a per-requester
// scoreboard of expected results (pushed on the cycle a request is accepted,
// popped when the response handshake completes) and runs directed scenarios.
module tb_adder_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0_valid, r0_ready, r0_cin, r0_rsp_valid, r0_rsp_ready;
  logic [7:0] r0_a, r0_b, r0_y;
  logic       r1_valid, r1_ready, r1_cin, r1_rsp_valid, r1_rsp_ready;
  logic [7:0] r1_a, r1_b, r1_y;
  logic [7:0] add_a, add_b, add_y;
  logic       add_cin;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         grant_log[$];

  always #5 clk = ~clk;

  // Behavioural model of the shared combinational adder.
  assign add_y = add_a + add_b + {7'b0, add_cin};

  adder_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_cin(r0_cin), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r0_y(r0_y),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_cin(r1_cin), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .r1_y(r1_y),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_y(add_y),
    .busy(busy)
  );

  function automatic logic [7:0] model_sum(input logic [7:0] a, input logic [7:0] b,
                                           input logic c);
    logic [8:0] full;
    full = {1'b0, a} + {1'b0, b} + {8'b0, c};
    return full[7:0];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (r0_ready && r1_ready) check_eq("both_ready", 1, 0);
      if (r0_ready) begin
        q0.push_back(model_sum(r0_a, r0_b, r0_cin));
        grant_log.push_back(0);
      end
      if (r1_ready) begin
        q1.push_back(model_sum(r1_a, r1_b, r1_cin));
        grant_log.push_back(1);
      end
      if (r0_rsp_valid && r0_rsp_ready) begin
        if (q0.size() == 0) check_eq("r0_unexpected_rsp", 1, 0);
        else                check_eq("r0_y_sb", r0_y, q0.pop_front());
      end
      if (r1_rsp_valid && r1_rsp_ready) begin
        if (q1.size() == 0) check_eq("r1_unexpected_rsp", 1, 0);
        else                check_eq("r1_y_sb", r1_y, q1.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_valid = 0; r0_a = 0; r0_b = 0; r0_cin = 0; r0_rsp_ready = 1;
    r1_valid = 0; r1_a = 0; r1_b = 0; r1_cin = 0; r1_rsp_ready = 1;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
    q0.delete();
    q1.delete();
    grant_log.delete();
  endtask

  // Waits (bounded) for all outstanding operations to complete.
  task automatic wait_done(input string tag);
    int n = 0;
    while ((busy || q0.size() != 0 || q1.size() != 0) && n < 50) begin
      step();
      n++;
    end
    check_eq(tag, (n < 50), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  n;
    int  busy_cnt;
    logic seen;

    idle_inputs();
    do_reset();

    // Reset state
    check_eq("rst_busy", busy, 0);
    check_eq("rst_add_a", add_a, 0);
    check_eq("rst_add_b", add_b, 0);
    check_eq("rst_add_cin", add_cin, 0);
    check_eq("rst_r0_y", r0_y, 0);
    check_eq("rst_r1_y", r1_y, 0);
    check_eq("rst_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 0);
    check_eq("rst_ready", {r0_ready, r1_ready}, 0);

    // 1: r0 AA + 8A + 1 -> 35; ready one cycle, response two cycles later
    r0_valid = 1; r0_a = 8'hAA; r0_b = 8'h8A; r0_cin = 1;
    #1;
    check_eq("t1_ready", r0_ready, 1);
    step();
    r0_valid = 0;
    check_eq("t1_ready_drop", r0_ready, 0);
    check_eq("t1_add_a", add_a, 8'hAA);
    check_eq("t1_calc_no_rsp", r0_rsp_valid, 0);
    step();
    check_eq("t1_rsp_valid", r0_rsp_valid, 1);
    check_eq("t1_y", r0_y, 8'h35);
    step();
    check_eq("t1_rsp_done", r0_rsp_valid, 0);
    check_eq("t1_add_hold", add_a, 8'hAA);
    wait_done("t1_done");

    // 2: r1 AA + 8A + 0 -> 34; r0 keeps its old y and sees no response
    r1_valid = 1; r1_a = 8'hAA; r1_b = 8'h8A; r1_cin = 0;
    #1;
    check_eq("t2_r1_ready", r1_ready, 1);
    check_eq("t2_r0_ready", r0_ready, 0);
    step();
    r1_valid = 0;
    step();
    check_eq("t2_rsp_valid", r1_rsp_valid, 1);
    check_eq("t2_y", r1_y, 8'h34);
    check_eq("t2_r0_quiet", r0_rsp_valid, 0);
    check_eq("t2_r0_y_hold", r0_y, 8'h35);
    wait_done("t2_done");

    // 4: r0 response back-pressured 5 cycles; r1 request waits
    r0_valid = 1; r0_a = 8'h10; r0_b = 8'h22; r0_cin = 1;
    step();
    r0_valid = 0; r0_rsp_ready = 0;
    r1_valid = 1; r1_a = 8'h05; r1_b = 8'h06; r1_cin = 0;
    check_eq("t4_calc_r1_ready", r1_ready, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t4_hold_valid", r0_rsp_valid, 1);
      check_eq("t4_hold_y", r0_y, 8'h33);
      check_eq("t4_r1_blocked", r1_ready, 0);
    end
    r0_rsp_ready = 1;
    step();
    check_eq("t4_r1_granted", r1_ready, 1);
    step();
    r1_valid = 0;
    wait_done("t4_done");

    // 5: reset during CALC drops the op
    r0_valid = 1; r0_a = 8'h01; r0_b = 8'h02; r0_cin = 0;
    step();
    r0_valid = 0;
    check_eq("t5_in_calc", busy, 1);
    rst = 1;
    step();
    rst = 0;
    q0.delete();
    q1.delete();
    check_eq("t5_busy", busy, 0);
    check_eq("t5_add_a", add_a, 0);
    check_eq("t5_add_b", add_b, 0);
    check_eq("t5_r0_y", r0_y, 0);
    check_eq("t5_r1_y", r1_y, 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      seen = seen | r0_rsp_valid | r1_rsp_valid;
      step();
    end
    check_eq("t5_no_rsp", seen, 0);

    // 6: wrap-around FF + 01 + 1 -> 01; busy spans CALC and RESP only
    r0_valid = 1; r0_a = 8'hFF; r0_b = 8'h01; r0_cin = 1;
    #1;
    check_eq("t6_accept_not_busy", busy, 0);
    step();
    r0_valid = 0;
    busy_cnt = 0;
    n = 0;
    while (busy && n < 20) begin
      busy_cnt++;
      if (r0_rsp_valid) check_eq("t6_y", r0_y, 8'h01);
      step();
      n++;
    end
    check_eq("t6_busy_cycles", busy_cnt, 2);
    wait_done("t6_done");

    // 3: both valid every cycle from reset -> r0, r1, r0, r1
    do_reset();
    r0_valid = 1; r1_valid = 1;
    n = 0;
    while (grant_log.size() < 4 && n < 40) begin
      r0_a = 8'($urandom); r0_b = 8'($urandom); r0_cin = 1'($urandom);
      r1_a = 8'($urandom); r1_b = 8'($urandom); r1_cin = 1'($urandom);
      step();
      n++;
    end
    r0_valid = 0; r1_valid = 0;
    check_eq("t3_grant_count", (grant_log.size() >= 4), 1);
    if (grant_log.size() >= 4) begin
      check_eq("t3_grant0", grant_log[0], 0);
      check_eq("t3_grant1", grant_log[1], 1);
      check_eq("t3_grant2", grant_log[2], 0);
      check_eq("t3_grant3", grant_log[3], 1);
    end
    wait_done("t3_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
